// File: rtl/reflet_periph_pkg.sv
// Shared types and constants for the Reflet peripheral bus and its watchdog.
// Status register offsets are relative to the end of the slot region.
package reflet_periph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } bus_state_t;

  localparam int ERR_ADDR_OFS   = 0;
  localparam int ERR_STAT_OFS   = 1;
  localparam int STAT_FLAG_BIT  = 0;
  localparam int STAT_COUNT_LSB = 1;
  localparam int ERR_COUNT_W    = 8;

endpackage

// File: rtl/reflet_bus_watchdog.sv
// Access wait counter with timeout detection, plus the saturating error counter
// that feeds the count field of the error status register.
module reflet_bus_watchdog
  import reflet_periph_pkg::*;
#(
  parameter int timeout_cycles = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wait_clear,
  input  logic                   wait_en,
  output logic                   timed_out,
  input  logic                   err_inc,
  input  logic                   err_clear,
  output logic [ERR_COUNT_W-1:0] err_count
);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || wait_clear) begin
      wait_cnt <= '0;
    end else if (wait_en) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fires in the access cycle whose increment brings the count to timeout_cycles.
  assign timed_out = wait_en && (wait_cnt == 8'(timeout_cycles - 1));

  always_ff @(posedge clk) begin
    if (reset || err_clear) begin
      err_count <= '0;
    end else if (err_inc && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: rtl/reflet_peripheral_bus.sv
// Peripheral interconnect: decodes a CPU window into uniform slots, waits for
// the selected slot's ready, and aborts slow accesses into two status registers.
module reflet_peripheral_bus
  import reflet_periph_pkg::*;
#(
  parameter int                        wordsize       = 16,
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF00,
  parameter int                        slot_count     = 8,
  parameter int                        slot_addr_bits = 3,
  parameter int                        timeout_cycles = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [base_addr_size-1:0]      addr,
  input  logic [wordsize-1:0]            data_in,
  input  logic                           write_en,
  output logic [wordsize-1:0]            data_out,
  output logic                           ready,
  output logic                           bus_error,
  output logic [slot_count-1:0]          slot_sel,
  output logic [slot_addr_bits-1:0]      slot_addr,
  output logic [wordsize-1:0]            slot_wdata,
  output logic                           slot_we,
  input  logic [slot_count*wordsize-1:0] slot_rdata,
  input  logic [slot_count-1:0]          slot_ready
);

  localparam int S     = slot_count << slot_addr_bits;
  localparam int IDX_W = (slot_count > 1) ? $clog2(slot_count) : 1;
  localparam logic [base_addr_size:0]   SLOT_LIMIT   = (base_addr_size + 1)'(S);
  localparam logic [base_addr_size-1:0] ERR_ADDR_OFF = base_addr_size'(S + ERR_ADDR_OFS);
  localparam logic [base_addr_size-1:0] ERR_STAT_OFF = base_addr_size'(S + ERR_STAT_OFS);

  bus_state_t                  state, state_next;
  logic [base_addr_size-1:0]   offset, req_offset;
  logic                        slot_hit, err_addr_hit, err_stat_hit, hit;
  logic [IDX_W-1:0]            slot_idx, sel_idx;
  logic                        slot_done, timed_out, err_flag;
  logic [ERR_COUNT_W-1:0]      err_count;
  logic [wordsize-1:0]         err_addr, err_stat;

  // Wrapping subtraction makes addresses below base_addr look huge, so they never hit.
  assign offset       = addr - base_addr;
  assign slot_hit     = enable && ({1'b0, offset} < SLOT_LIMIT);
  assign err_addr_hit = enable && (offset == ERR_ADDR_OFF);
  assign err_stat_hit = enable && (offset == ERR_STAT_OFF);
  assign hit          = slot_hit || err_addr_hit || err_stat_hit;
  assign slot_idx     = IDX_W'(offset >> slot_addr_bits);
  assign slot_done    = (state == ACCESS) && slot_ready[sel_idx];

  always_comb begin
    err_stat = '0;
    err_stat[STAT_FLAG_BIT] = err_flag;
    err_stat[STAT_COUNT_LSB +: ERR_COUNT_W] = err_count;
  end

  reflet_bus_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .wait_clear(state != ACCESS),
    .wait_en   (state == ACCESS),
    .timed_out (timed_out),
    .err_inc   (timed_out && !slot_done),
    .err_clear ((state == IDLE) && err_stat_hit && write_en),
    .err_count (err_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = !hit;
        if (slot_hit)                          state_next = ACCESS;
        else if (err_addr_hit || err_stat_hit) state_next = DONE;
      end
      ACCESS: begin
        if (slot_done || timed_out) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      bus_error  <= 1'b0;
      slot_sel   <= '0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      slot_we    <= 1'b0;
      sel_idx    <= '0;
      req_offset <= '0;
      err_addr   <= '0;
      err_flag   <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          data_out <= '0;
          if (slot_hit) begin
            sel_idx    <= slot_idx;
            req_offset <= offset;
            slot_addr  <= offset[slot_addr_bits-1:0];
            slot_wdata <= data_in;
            slot_we    <= write_en;
            slot_sel   <= slot_count'(1) << slot_idx;
          end else if (err_addr_hit && !write_en) begin
            data_out <= err_addr;
          end else if (err_stat_hit) begin
            if (write_en) err_flag <= 1'b0;
            else          data_out <= err_stat;
          end
        end
        ACCESS: begin
          // A ready arriving in the timeout cycle still counts as a normal completion.
          if (slot_done) begin
            data_out <= slot_we ? '0 : slot_rdata[int'(sel_idx)*wordsize +: wordsize];
            slot_sel <= '0;
            slot_we  <= 1'b0;
          end else if (timed_out) begin
            data_out  <= '0;
            err_addr  <= wordsize'(req_offset);
            err_flag  <= 1'b1;
            bus_error <= 1'b1;
            slot_sel  <= '0;
            slot_we   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_peripheral_bus.sv
// Directed bench for reflet_peripheral_bus: a table of whole transactions with
// hand-computed results, plus reset-abort and error-count saturation sequences.
module tb_reflet_peripheral_bus;

  logic         clk = 1'b0;
  logic         reset, enable, write_en;
  logic [15:0]  addr, data_in;
  logic [15:0]  data_out, slot_wdata;
  logic         ready, bus_error, slot_we;
  logic [7:0]   slot_sel, slot_ready;
  logic [2:0]   slot_addr;
  logic [127:0] slot_rdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [7:0]  noise;
    int          delay;
    logic [7:0]  exp_sel;
    logic [2:0]  exp_saddr;
    int          exp_lat;
    logic [15:0] exp_data;
    logic        exp_berr;
  } vec_t;

  vec_t vecs[19];

  reflet_peripheral_bus dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .data_out  (data_out),
    .ready     (ready),
    .bus_error (bus_error),
    .slot_sel  (slot_sel),
    .slot_addr (slot_addr),
    .slot_wdata(slot_wdata),
    .slot_we   (slot_we),
    .slot_rdata(slot_rdata),
    .slot_ready(slot_ready)
  );

  always #5 clk = ~clk;

  // Slot 7 down to slot 0
  assign slot_rdata = {16'hC0DE, 16'h6666, 16'h5555, 16'h4444,
                       16'h3333, 16'h2222, 16'hBEEF, 16'h0A0A};

  initial begin
    #1000000;
    $display("[TB] FAIL sim_timeout: actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic vec_t mkVec(input logic [15:0] a, input logic we, input logic [15:0] wd,
                                 input logic [7:0] noise, input int delay, input logic [7:0] sel,
                                 input logic [2:0] saddr, input int lat, input logic [15:0] d,
                                 input logic berr);
    vec_t v;
    v.addr = a; v.we = we; v.wdata = wd; v.noise = noise; v.delay = delay;
    v.exp_sel = sel; v.exp_saddr = saddr; v.exp_lat = lat; v.exp_data = d; v.exp_berr = berr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU transaction: hold the request until ready, then drop enable for a cycle.
  task automatic applyStimulus(input vec_t v);
    bit done;
    tick();
    enable = 1'b1; addr = v.addr; data_in = v.wdata; write_en = v.we; slot_ready = v.noise;
    #1;
    checkOutput("req_ready", ready, v.exp_lat == 0);
    if (v.exp_lat == 0) begin
      tick();
      #1;
      checkOutput("nohit_data", data_out, 0);
      checkOutput("nohit_sel", slot_sel, 0);
      checkOutput("nohit_ready", ready, 1);
    end else begin
      done = 1'b0;
      for (int c = 1; c <= 40 && !done; c++) begin
        tick();
        slot_ready = v.noise | ((c == v.delay + 1) ? v.exp_sel : 8'h00);
        #1;
        if (ready) begin
          done = 1'b1;
          checkOutput("latency", c, v.exp_lat);
          checkOutput("done_data", data_out, v.exp_data);
          checkOutput("done_berr", bus_error, v.exp_berr);
          checkOutput("done_sel", slot_sel, 0);
          checkOutput("done_we", slot_we, 0);
        end else begin
          checkOutput("access_sel", slot_sel, v.exp_sel);
          checkOutput("access_berr", bus_error, 0);
          if (c == 1) begin
            checkOutput("access_saddr", slot_addr, v.exp_saddr);
            checkOutput("access_we", slot_we, v.we);
            if (v.we) checkOutput("access_wdata", slot_wdata, v.wdata);
          end
        end
      end
      if (!done) checkOutput("ready_bound", ready, 1);
    end
    tick();
    enable = 1'b0; write_en = 1'b0; slot_ready = 8'h00;
    #1;
    checkOutput("idle_ready", ready, 1);
    checkOutput("idle_berr", bus_error, 0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = 16'h0000; data_in = 16'h0000; slot_ready = 8'h00;

    //             addr      we    wdata     noise  dly sel    sa    lat data      berr
    vecs[0]  = mkVec(16'hFF09, 1'b0, 16'h0000, 8'h00,  0, 8'h02, 3'd1, 2, 16'hBEEF, 1'b0);
    vecs[1]  = mkVec(16'hFF3F, 1'b1, 16'h1234, 8'h00,  4, 8'h80, 3'd7, 6, 16'h0000, 1'b0);
    vecs[2]  = mkVec(16'hFF10, 1'b0, 16'h0000, 8'hFB, -1, 8'h04, 3'd0, 16, 16'h0000, 1'b1);
    vecs[3]  = mkVec(16'hFF40, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0010, 1'b0);
    vecs[4]  = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0003, 1'b0);
    vecs[5]  = mkVec(16'hFF12, 1'b0, 16'h0000, 8'h08,  2, 8'h04, 3'd2, 4, 16'h2222, 1'b0);
    vecs[6]  = mkVec(16'hFF18, 1'b0, 16'h0000, 8'h00, 14, 8'h08, 3'd0, 16, 16'h3333, 1'b0);
    vecs[7]  = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0003, 1'b0);
    vecs[8]  = mkVec(16'hFEFF, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 0, 16'h0000, 1'b0);
    vecs[9]  = mkVec(16'hFF42, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 0, 16'h0000, 1'b0);
    vecs[10] = mkVec(16'hFF40, 1'b1, 16'hFFFF, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    vecs[11] = mkVec(16'hFF40, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0010, 1'b0);
    vecs[12] = mkVec(16'hFF00, 1'b1, 16'h5A5A, 8'h00,  0, 8'h01, 3'd0, 2, 16'h0000, 1'b0);
    vecs[13] = mkVec(16'hFF38, 1'b0, 16'h0000, 8'h00,  1, 8'h80, 3'd0, 3, 16'hC0DE, 1'b0);
    vecs[14] = mkVec(16'hFF41, 1'b1, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    vecs[15] = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    vecs[16] = mkVec(16'hFF2B, 1'b0, 16'h0000, 8'h00, -1, 8'h20, 3'd3, 16, 16'h0000, 1'b1);
    vecs[17] = mkVec(16'hFF40, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h002B, 1'b0);
    vecs[18] = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0003, 1'b0);

    repeat (3) tick();
    #1;
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_sel", slot_sel, 0);
    checkOutput("reset_we", slot_we, 0);
    checkOutput("reset_saddr", slot_addr, 0);
    checkOutput("reset_wdata", slot_wdata, 0);
    checkOutput("reset_berr", bus_error, 0);
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset in the middle of an access abandons it without logging an error.
    tick();
    enable = 1'b1; addr = 16'hFF20; write_en = 1'b0; slot_ready = 8'h00;
    tick();
    tick();
    #1;
    checkOutput("pre_reset_sel", slot_sel, 8'h10);
    reset = 1'b1; enable = 1'b0;
    tick();
    #1;
    checkOutput("abort_sel", slot_sel, 0);
    checkOutput("abort_ready", ready, 1);
    checkOutput("abort_berr", bus_error, 0);
    reset = 1'b0;
    v = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    applyStimulus(v);
    v = mkVec(16'hFF40, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    applyStimulus(v);

    // Error count saturates at 255, then a status write clears it.
    v = mkVec(16'hFF10, 1'b0, 16'h0000, 8'h00, -1, 8'h04, 3'd0, 16, 16'h0000, 1'b1);
    for (int n = 0; n < 300; n++) applyStimulus(v);
    v = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h01FF, 1'b0);
    applyStimulus(v);
    v = mkVec(16'hFF41, 1'b1, 16'hABCD, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    applyStimulus(v);
    v = mkVec(16'hFF41, 1'b0, 16'h0000, 8'h00, -1, 8'h00, 3'd0, 1, 16'h0000, 1'b0);
    applyStimulus(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
